// File: rtl/result_writeback_pkg.sv
// Shared decode constants for the writeback stage: destination encoding and commit-id width.
package result_writeback_pkg;
    localparam logic [3:0] WB_DEST_ACC = 4'hF;
    localparam int COMMIT_ID_W = 9;
    typedef logic [COMMIT_ID_W-1:0] commit_id_t;
endpackage

// File: rtl/wb_stall_watchdog.sv
// Counts enabled cycles with pending but unadmitted input; raises a sticky error at stall_limit.
module wb_stall_watchdog #(
    parameter int stall_limit = 1023,
    localparam int cw = ($clog2(stall_limit + 1) > 10) ? $clog2(stall_limit + 1) : 10
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic pending,
    input  logic admit,
    output logic stall_error
);
    localparam logic [cw-1:0] limit = cw'(stall_limit);

    logic [cw-1:0] count_reg, count_next;
    logic          stall_error_reg, stall_error_next;

    // Counter parks at the limit so the comparison stays true until an admission clears it.
    always_comb begin
        count_next = count_reg;
        if (enable) begin
            if (admit)
                count_next = '0;
            else if (pending && (count_reg != limit))
                count_next = count_reg + cw'(1);
        end
        stall_error_next = stall_error_reg | (count_next == limit);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg       <= '0;
            stall_error_reg <= 1'b0;
        end else begin
            count_reg       <= count_next;
            stall_error_reg <= stall_error_next;
        end
    end

    assign stall_error = stall_error_reg;
endmodule

// File: rtl/result_writeback.sv
// In-order writeback: admits branch result tokens in commit_id order and turns them into
// registered register-file / accumulator writes plus commit pulses.
module result_writeback
    import result_writeback_pkg::*;
#(
    parameter int data_width  = 16,
    parameter int n_blocks    = 256,
    parameter int n_inputs    = 2,
    parameter int stall_limit = 1023,
    localparam int bw = $clog2(n_blocks)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [n_inputs-1:0]              in_valid,
    output logic [n_inputs-1:0]              in_ready,
    input  logic [n_inputs*bw-1:0]           block_in,
    input  logic [n_inputs*4-1:0]            dest_in,
    input  logic [n_inputs*2*data_width-1:0] result_in,
    input  logic [n_inputs*COMMIT_ID_W-1:0]  commit_id_in,
    input  logic [n_inputs-1:0]              commit_flag_in,
    output logic                             reg_we,
    output logic [bw-1:0]                    reg_block,
    output logic [3:0]                       reg_addr,
    output logic [data_width-1:0]            reg_data,
    output logic                             acc_we,
    output logic [bw-1:0]                    acc_block,
    output logic [2*data_width-1:0]          acc_data,
    output logic                             commit_valid,
    output logic [bw-1:0]                    commit_block,
    output logic [COMMIT_ID_W-1:0]           commit_id_out,
    output logic [COMMIT_ID_W-1:0]           next_commit_id,
    output logic                             stall_error
);
    localparam int sw = (n_inputs > 1) ? $clog2(n_inputs) : 1;

    logic [n_inputs-1:0]     eligible;
    logic [n_inputs-1:0]     grant;
    logic [sw-1:0]           sel;
    logic                    admit;
    commit_id_t              next_id_reg;

    logic [bw-1:0]           sel_block;
    logic [3:0]              sel_dest;
    logic [2*data_width-1:0] sel_result;
    commit_id_t              sel_id;
    logic                    sel_flag;

    generate
        for (genvar gi = 0; gi < n_inputs; gi++) begin : g_elig
            assign eligible[gi] = in_valid[gi] &&
                                  (commit_id_in[gi*COMMIT_ID_W +: COMMIT_ID_W] == next_id_reg);
        end
    endgenerate

    // Lowest-index eligible lane wins; duplicates on higher lanes wait a cycle.
    always_comb begin
        grant = '0;
        sel   = '0;
        for (int i = n_inputs - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant = '0;
                grant[i] = 1'b1;
                sel = sw'(i);
            end
        end
    end

    assign in_ready = grant & {n_inputs{enable & ~reset}};
    assign admit    = |in_ready;

    assign sel_block  = block_in[sel*bw +: bw];
    assign sel_dest   = dest_in[sel*4 +: 4];
    assign sel_result = result_in[sel*2*data_width +: 2*data_width];
    assign sel_id     = commit_id_in[sel*COMMIT_ID_W +: COMMIT_ID_W];
    assign sel_flag   = commit_flag_in[sel];

    // Strobes default low every cycle so each admission yields exactly one pulse; data holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_id_reg   <= '0;
            reg_we        <= 1'b0;
            reg_block     <= '0;
            reg_addr      <= '0;
            reg_data      <= '0;
            acc_we        <= 1'b0;
            acc_block     <= '0;
            acc_data      <= '0;
            commit_valid  <= 1'b0;
            commit_block  <= '0;
            commit_id_out <= '0;
        end else begin
            reg_we       <= 1'b0;
            acc_we       <= 1'b0;
            commit_valid <= 1'b0;
            if (admit) begin
                next_id_reg <= next_id_reg + COMMIT_ID_W'(1);
                if (sel_dest == WB_DEST_ACC) begin
                    acc_we    <= 1'b1;
                    acc_block <= sel_block;
                    acc_data  <= sel_result;
                end else begin
                    reg_we    <= 1'b1;
                    reg_block <= sel_block;
                    reg_addr  <= sel_dest;
                    reg_data  <= sel_result[data_width-1:0];
                end
                if (sel_flag) begin
                    commit_valid  <= 1'b1;
                    commit_block  <= sel_block;
                    commit_id_out <= sel_id;
                end
            end
        end
    end

    assign next_commit_id = next_id_reg;

    wb_stall_watchdog #(.stall_limit(stall_limit)) u_watchdog (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pending     (|in_valid),
        .admit       (admit),
        .stall_error (stall_error)
    );
endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback: ordering, priority, accumulator/commit path, wrap,
// stall watchdog and asynchronous reset.
module tb_result_writeback;
    localparam int DW = 16;
    localparam int NB = 256;
    localparam int NI = 2;
    localparam int BW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b1;
    logic [NI-1:0]   in_valid = '0;
    logic [NI-1:0]   in_ready;
    logic [NI*BW-1:0] block_in = '0;
    logic [NI*4-1:0] dest_in = '0;
    logic [NI*32-1:0] result_in = '0;
    logic [NI*9-1:0] commit_id_in = '0;
    logic [NI-1:0]   commit_flag_in = '0;
    logic            reg_we, acc_we, commit_valid, stall_error;
    logic [BW-1:0]   reg_block, acc_block, commit_block;
    logic [3:0]      reg_addr;
    logic [DW-1:0]   reg_data;
    logic [31:0]     acc_data;
    logic [8:0]      commit_id_out, next_commit_id;

    int total = 0;
    int bad = 0;

    result_writeback #(.data_width(DW), .n_blocks(NB), .n_inputs(NI), .stall_limit(8)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready),
        .block_in(block_in), .dest_in(dest_in), .result_in(result_in),
        .commit_id_in(commit_id_in), .commit_flag_in(commit_flag_in),
        .reg_we(reg_we), .reg_block(reg_block), .reg_addr(reg_addr), .reg_data(reg_data),
        .acc_we(acc_we), .acc_block(acc_block), .acc_data(acc_data),
        .commit_valid(commit_valid), .commit_block(commit_block),
        .commit_id_out(commit_id_out), .next_commit_id(next_commit_id),
        .stall_error(stall_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int lane, input logic v, input logic [7:0] blk, input logic [3:0] d,
                         input logic [31:0] r, input logic [8:0] id, input logic f);
        in_valid[lane]           = v;
        block_in[lane*BW +: BW]  = blk;
        dest_in[lane*4 +: 4]     = d;
        result_in[lane*32 +: 32] = r;
        commit_id_in[lane*9 +: 9] = id;
        commit_flag_in[lane]     = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held: everything quiet, no ready even with a matching token.
        drive(0, 1'b1, 8'd2, 4'd3, 32'h0001_2345, 9'd0, 1'b0);
        #2;
        chk("rst_ready", in_ready, 2'b00);
        chk("rst_next", next_commit_id, 9'd0);
        chk("rst_stall", stall_error, 1'b0);
        chk("rst_regwe", reg_we, 1'b0);
        step();
        #3 reset = 1'b0;
        #1;
        // Lane 0, id 0, dest 3.
        chk("t1_ready", in_ready, 2'b01);
        step();
        drive(0, 1'b0, 8'd0, 4'd0, 32'd0, 9'd0, 1'b0);
        $display("txn id=0 reg write addr=%0d data=%h", reg_addr, reg_data);
        chk("t1_regwe", reg_we, 1'b1);
        chk("t1_addr", reg_addr, 4'd3);
        chk("t1_data", reg_data, 16'h2345);
        chk("t1_block", reg_block, 8'd2);
        chk("t1_accwe", acc_we, 1'b0);
        chk("t1_commit", commit_valid, 1'b0);
        chk("t1_next", next_commit_id, 9'd1);

        // Lane 1 id 1 and lane 0 id 2 together: lane 1 first, then lane 0.
        drive(1, 1'b1, 8'd4, 4'd5, 32'h0000_0011, 9'd1, 1'b0);
        drive(0, 1'b1, 8'd6, 4'd6, 32'h0000_0022, 9'd2, 1'b0);
        #1;
        chk("t2_ready_a", in_ready, 2'b10);
        step();
        drive(1, 1'b0, 8'd0, 4'd0, 32'd0, 9'd0, 1'b0);
        $display("txn id=1 reg write addr=%0d data=%h", reg_addr, reg_data);
        chk("t2_data_a", reg_data, 16'h0011);
        chk("t2_addr_a", reg_addr, 4'd5);
        chk("t2_next_a", next_commit_id, 9'd2);
        chk("t2_ready_b", in_ready, 2'b01);
        step();
        drive(0, 1'b0, 8'd0, 4'd0, 32'd0, 9'd0, 1'b0);
        $display("txn id=2 reg write addr=%0d data=%h", reg_addr, reg_data);
        chk("t2_regwe_b", reg_we, 1'b1);
        chk("t2_data_b", reg_data, 16'h0022);
        chk("t2_addr_b", reg_addr, 4'd6);
        chk("t2_next_b", next_commit_id, 9'd3);
        step();
        chk("t2_regwe_idle", reg_we, 1'b0);

        // Accumulator write with commit.
        drive(0, 1'b1, 8'd7, 4'hF, 32'hFFFF_8000, 9'd3, 1'b1);
        step();
        drive(0, 1'b0, 8'd0, 4'd0, 32'd0, 9'd0, 1'b0);
        $display("txn id=3 acc write block=%0d data=%h commit=%0b", acc_block, acc_data, commit_valid);
        chk("t3_accwe", acc_we, 1'b1);
        chk("t3_accdata", acc_data, 32'hFFFF_8000);
        chk("t3_accblk", acc_block, 8'd7);
        chk("t3_commit", commit_valid, 1'b1);
        chk("t3_cblock", commit_block, 8'd7);
        chk("t3_cid", commit_id_out, 9'd3);
        chk("t3_regwe", reg_we, 1'b0);
        step();
        chk("t3_commit_once", commit_valid, 1'b0);

        // Back-to-back ids 4..511, then 0 across the wrap.
        for (int k = 4; k <= 511; k++) begin
            drive(0, 1'b1, 8'd1, 4'd1, 32'(k), 9'(k), (k == 511));
            step();
        end
        $display("txn id=511 commit id=%0d next=%0d", commit_id_out, next_commit_id);
        chk("wrap_regwe", reg_we, 1'b1);
        chk("wrap_data", reg_data, 16'h01FF);
        chk("wrap_cid511", commit_id_out, 9'd511);
        chk("wrap_next0", next_commit_id, 9'd0);
        drive(0, 1'b1, 8'd9, 4'd1, 32'h0000_0200, 9'd0, 1'b1);
        step();
        $display("txn id=0 commit id=%0d next=%0d", commit_id_out, next_commit_id);
        chk("wrap_commit0", commit_valid, 1'b1);
        chk("wrap_cid0", commit_id_out, 9'd0);
        chk("wrap_cblk", commit_block, 8'd9);
        chk("wrap_next1", next_commit_id, 9'd1);

        // Enable low: a matching token is not accepted and nothing changes.
        enable = 1'b0;
        drive(0, 1'b1, 8'd3, 4'd4, 32'h0000_4444, 9'd1, 1'b0);
        #1;
        chk("en_ready", in_ready, 2'b00);
        step();
        chk("en_regwe", reg_we, 1'b0);
        chk("en_next", next_commit_id, 9'd1);
        drive(0, 1'b0, 8'd0, 4'd0, 32'd0, 9'd0, 1'b0);
        enable = 1'b1;

        // Async reset mid-cycle clears state immediately.
        #2 reset = 1'b1;
        #1;
        chk("rst2_next", next_commit_id, 9'd0);
        chk("rst2_data", reg_data, 16'h0000);
        #2 reset = 1'b0;

        // Stall watchdog: id 5 pending while waiting for 0.
        drive(0, 1'b1, 8'd5, 4'd2, 32'h0000_5555, 9'd5, 1'b0);
        for (int c = 0; c < 7; c++) step();
        chk("stall_pre", stall_error, 1'b0);
        step();
        chk("stall_set", stall_error, 1'b1);
        drive(1, 1'b1, 8'd8, 4'd2, 32'h0000_1234, 9'd0, 1'b1);
        #1;
        chk("stall_ready", in_ready, 2'b10);
        step();
        $display("txn id=0 reg write addr=%0d data=%h stall=%0b", reg_addr, reg_data, stall_error);
        chk("stall_regwe", reg_we, 1'b1);
        chk("stall_data", reg_data, 16'h1234);
        chk("stall_sticky", stall_error, 1'b1);
        chk("stall_next", next_commit_id, 9'd1);

        // Reset while strobes are high, with enable toggling.
        #2 reset = 1'b1;
        enable = 1'b0;
        #1;
        chk("rst3_regwe", reg_we, 1'b0);
        chk("rst3_commit", commit_valid, 1'b0);
        chk("rst3_stall", stall_error, 1'b0);
        chk("rst3_ready", in_ready, 2'b00);
        chk("rst3_next", next_commit_id, 9'd0);
        drive(1, 1'b0, 8'd0, 4'd0, 32'd0, 9'd0, 1'b0);
        drive(0, 1'b1, 8'd10, 4'd9, 32'h0000_ABCD, 9'd0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("rst3_en_ready", in_ready, 2'b00);
        step();
        chk("rst3_en_regwe", reg_we, 1'b0);
        enable = 1'b1;
        #1;
        chk("rst3_ready_on", in_ready, 2'b01);
        step();
        drive(0, 1'b0, 8'd0, 4'd0, 32'd0, 9'd0, 1'b0);
        $display("txn id=0 reg write addr=%0d data=%h", reg_addr, reg_data);
        chk("post_regwe", reg_we, 1'b1);
        chk("post_data", reg_data, 16'hABCD);
        chk("post_addr", reg_addr, 4'd9);
        chk("post_next", next_commit_id, 9'd1);
        chk("post_stall", stall_error, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
